// File: rtl/neuron_forward.sv
// Sequential ReLU neuron: accumulates N_INPUTS x*w products onto a bias, then presents y/acc/gate.
// Define NF_SATURATE_EN to clamp each accumulation step to 32-bit signed range (default: wrap).
module neuron_forward #(
  parameter int N_INPUTS = 4,
  parameter int FRAC     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nf_in_valid,
  output logic               nf_in_ready,
  input  logic signed [31:0] nf_x,
  input  logic signed [31:0] nf_w,
  input  logic signed [31:0] nf_bias,
  output logic               nf_out_valid,
  input  logic               nf_out_ready,
  output logic        [31:0] nf_y,
  output logic signed [31:0] nf_acc,
  output logic               nf_gate
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [1:0] {ACCUM, ACT, OUT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic signed [31:0] acc_sum;
  logic signed [63:0] prod_p0;
  logic signed [63:0] shift_p0;
  logic signed [31:0] base_p0;
  logic signed [64:0] sum_p0;
  logic               beat_ok;
  logic               last_beat;

  function automatic logic signed [31:0] reduce_sum(input logic signed [64:0] s);
`ifdef NF_SATURATE_EN
    if (s > 65'sh0_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (s < -65'sh0_8000_0000)
      return 32'sh8000_0000;
    else
      return 32'(s);
`else
    return 32'(s);
`endif
  endfunction

  // Stage p0: product, fixed-point shift and 65-bit sum of the accepted beat
  always_comb begin
    prod_p0  = 64'(nf_x) * 64'(nf_w);
    shift_p0 = prod_p0 >>> FRAC;
    base_p0  = (cnt == '0) ? nf_bias : acc_sum;
    sum_p0   = 65'(base_p0) + 65'(shift_p0);
  end

  assign beat_ok   = nf_in_valid && (state == ACCUM);
  assign last_beat = (cnt == CNT_W'(N_INPUTS - 1));

  always_comb begin
    state_nx     = state;
    nf_in_ready  = 1'b0;
    nf_out_valid = 1'b0;
    case (state)
      ACCUM: begin
        nf_in_ready = 1'b1;
        if (nf_in_valid && last_beat) state_nx = ACT;
      end
      ACT: state_nx = OUT;
      OUT: begin
        nf_out_valid = 1'b1;
        if (nf_out_ready) state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc_sum <= '0;
      nf_y    <= '0;
      nf_acc  <= '0;
      nf_gate <= 1'b0;
    end else begin
      state <= state_nx;
      if (beat_ok) begin
        acc_sum <= reduce_sum(sum_p0);
        cnt     <= last_beat ? '0 : cnt + 1'b1;
      end
      // Activation stage: results held until the next ACT overwrites them
      if (state == ACT) begin
        nf_acc  <= acc_sum;
        nf_y    <= acc_sum[31] ? 32'd0 : acc_sum;
        nf_gate <= ~acc_sum[31];
      end
    end
  end

endmodule
